// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the ALU/UART front end: FSM state encodings and ALU opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_uart_interface_pkg;

  // Controller states. WAIT_A is the only non-busy state.
  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CALC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  // ALU opcode values carried in the low six bits of the opcode byte.
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // True in the states where an operand sequence is partially received.
  function automatic logic is_collecting(input state_e s);
    return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
  endfunction

endpackage

// File: rtl/alu_uart_interface_inactivity_timer.sv
// Inactivity timer: counts enabled cycles, flags expiry on the LIMIT-th enabled cycle.
// Latency: expired_o is combinational from the count; the count updates one cycle after clear/enable.
// Backpressure: none; clear has priority over counting.
module inactivity_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Expiry only matters while the owner is actually waiting.
  assign expired_o = enable_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance while enabled and wrap on expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = expired_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_uart_interface.sv
// Collects A, B and opcode bytes from a UART receiver, drives an external ALU, sends the result back.
// Latency: o_tx_start is high in the second cycle after the edge that samples the opcode byte.
// Backpressure: bytes are ignored from CALC until i_tx_done returns the FSM to WAIT_A.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int BITS_DATA      = 8,
  parameter int BITS_OP        = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [BITS_DATA-1:0] i_rx_data,
  input  logic                 i_rx_done,
  input  logic [BITS_DATA-1:0] i_alu_result,
  input  logic                 i_tx_done,
  output logic [BITS_DATA-1:0] o_data_a,
  output logic [BITS_DATA-1:0] o_data_b,
  output logic [BITS_OP-1:0]   o_op,
  output logic [BITS_DATA-1:0] o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy
);

  state_e state_q;
  state_e state_d;

  logic [BITS_DATA-1:0] data_a_q, data_a_d;
  logic [BITS_DATA-1:0] data_b_q, data_b_d;
  logic [BITS_OP-1:0]   op_q, op_d;
  logic [BITS_DATA-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;

  logic timer_clear;
  logic timer_en;
  logic timeout;

  // Counter runs only while a sequence is half received; any byte or new wait state restarts it.
  assign timer_en    = is_collecting(state_q);
  assign timer_clear = i_rx_done || ((state_d != state_q) && is_collecting(state_d));

  inactivity_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (i_reset),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expired_o(timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a received byte beats a simultaneous timeout; i_tx_done only matters in WAIT_TX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (i_rx_done)    state_d = ST_WAIT_OP;
        else if (timeout) state_d = ST_WAIT_A;
      end
      ST_WAIT_OP: begin
        if (i_rx_done)    state_d = ST_CALC;
        else if (timeout) state_d = ST_WAIT_A;
      end
      ST_CALC:    state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) state_d = ST_WAIT_A;
      end
      default:    state_d = ST_WAIT_A;
    endcase
  end

  // Output/datapath next values: latch bytes in their slot, capture the ALU result in CALC.
  always_comb begin
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      ST_WAIT_A:  if (i_rx_done) data_a_d = i_rx_data;
      ST_WAIT_B:  if (i_rx_done) data_b_d = i_rx_data;
      ST_WAIT_OP: if (i_rx_done) op_d = i_rx_data[BITS_OP-1:0];
      ST_CALC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;  // registered, so the pulse lands in SEND
      end
      default: ;
    endcase
  end

  // Datapath registers; operands persist across sequences and timeouts.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != ST_WAIT_A);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed scenarios plus randomized byte/tx-done traffic.
// Latency: checks outputs every negedge against a transaction-level model.
// Backpressure: an auto responder returns i_tx_done 1..4 cycles after o_tx_start.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] i_alu_result;
  logic       i_tx_done;
  logic [7:0] o_data_a, o_data_b, o_tx_data;
  logic [5:0] o_op;
  logic       o_tx_start, o_busy;

  logic tx_resp = 1'b0;
  logic tx_spur = 1'b0;
  bit   auto_tx = 1'b1;
  int   resp_cnt = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(
    .BITS_DATA(8), .BITS_OP(6), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy)
  );

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return sa >>> b;
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu(o_data_a, o_data_b, o_op);
  assign i_tx_done    = tx_resp | tx_spur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: bytes gathered so far, idle edges, edges since the opcode byte.
  int         got = 0;
  int         idle = 0;
  int         since_op = 0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_tx = 8'h00;
  logic [5:0] m_op = 6'h00;

  always @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      got = 0; idle = 0; since_op = 0;
      m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
    end else if (got == 3) begin
      if (since_op >= 2 && i_tx_done) begin
        got = 0;
      end else begin
        since_op++;
        if (since_op == 1) m_tx = alu(m_a, m_b, m_op);
      end
    end else if (i_rx_done) begin
      if (got == 0)      m_a = i_rx_data;
      else if (got == 1) m_b = i_rx_data;
      else               m_op = i_rx_data[5:0];
      got++;
      idle = 0;
      if (got == 3) since_op = 0;
    end else if (got != 0) begin
      idle++;
      if (idle == T) begin
        got = 0;
        idle = 0;
      end
    end
  end

  // Compare process.
  initial forever begin
    @(negedge clk);
    chk("data_a", o_data_a, m_a);
    chk("data_b", o_data_b, m_b);
    chk("op", o_op, m_op);
    chk("tx_data", o_tx_data, m_tx);
    chk("tx_start", o_tx_start, (got == 3 && since_op == 1));
    chk("busy", o_busy, (got != 0));
  end

  // Transmitter stand-in.
  initial forever begin
    @(negedge clk);
    tx_resp = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) tx_resp = 1'b1;
    end
    if (auto_tx && o_tx_start) resp_cnt = int'($urandom_range(1, 4));
  end

  task automatic step(input logic rx, input logic [7:0] d, input logic sp);
    i_rx_done = rx;
    i_rx_data = d;
    tx_spur   = sp;
    @(negedge clk);
    i_rx_done = 1'b0;
    tx_spur   = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 40) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("wait_idle_bound", o_busy, 1'b0);
  endtask

  logic [5:0] ops [8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    i_reset = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_start", o_tx_start, 1'b0);
    chk("reset_a", o_data_a, 8'h00);
    i_reset = 1'b1;
    @(negedge clk);

    // ADD 5+3, latency pinned.
    send(8'h05); send(8'h03); send(8'h20);
    chk("lat_cycle1_start", o_tx_start, 1'b0);
    idle_n(1);
    chk("lat_cycle2_start", o_tx_start, 1'b1);
    chk("add_result", o_tx_data, 8'h08);
    wait_idle();

    // SRA with manual tx done; busy falls right after it.
    auto_tx = 1'b0;
    send(8'hF0); send(8'h02); send(8'h03);
    idle_n(1);
    chk("sra_result", o_tx_data, 8'hFC);
    idle_n(3);
    chk("sra_busy_wait_tx", o_busy, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("sra_busy_fell", o_busy, 1'b0);

    // Bytes injected during WAIT_TX are ignored.
    send(8'h11); send(8'h22); send(8'h20);
    idle_n(2);
    for (int k = 0; k < 4; k++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    chk("inject_a", o_data_a, 8'h11);
    chk("inject_b", o_data_b, 8'h22);
    chk("inject_tx", o_tx_data, 8'h33);
    step(1'b0, 8'h00, 1'b1);
    send(8'h07); send(8'h02); send(8'h22);
    idle_n(2);
    chk("after_inject_sub", o_tx_data, 8'h05);

    // rx_done coincident with tx_done in WAIT_TX is dropped.
    step(1'b1, 8'hAA, 1'b1);
    chk("coinc_busy", o_busy, 1'b0);
    chk("coinc_a", o_data_a, 8'h07);
    send(8'h5A);
    chk("coinc_next_a", o_data_a, 8'h5A);
    send(8'h01); send(8'h26);
    idle_n(2);
    chk("xor_result", o_tx_data, 8'h5B);
    step(1'b0, 8'h00, 1'b1);

    // Timeout after T silent cycles; byte on the expiry edge wins.
    send(8'h77);
    idle_n(T - 1);
    chk("timeout_not_yet", o_busy, 1'b1);
    idle_n(1);
    chk("timeout_busy", o_busy, 1'b0);
    chk("timeout_keeps_a", o_data_a, 8'h77);
    send(8'h12);
    chk("timeout_next_is_a", o_data_a, 8'h12);
    idle_n(T - 1);
    send(8'h34);
    chk("expiry_priority_busy", o_busy, 1'b1);
    chk("expiry_priority_b", o_data_b, 8'h34);
    send(8'hE4);
    chk("op_upper_discarded", o_op, 6'h24);
    idle_n(2);
    chk("and_result", o_tx_data, 8'h10);
    step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset in WAIT_OP.
    send(8'h09); send(8'h08);
    #3 i_reset = 1'b0;
    #1;
    chk("arst_a", o_data_a, 8'h00);
    chk("arst_b", o_data_b, 8'h00);
    chk("arst_op", o_op, 6'h00);
    chk("arst_busy", o_busy, 1'b0);
    @(negedge clk);
    i_reset = 1'b1;
    send(8'h01); send(8'h01); send(8'h22);
    idle_n(1);
    chk("post_reset_start", o_tx_start, 1'b1);
    chk("post_reset_sub", o_tx_data, 8'h00);
    step(1'b0, 8'h00, 1'b1);

    // Randomized traffic.
    auto_tx = 1'b1;
    begin
      int pct;
      pct = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 200 == 0) pct = ($urandom_range(0, 1) != 0) ? 50 : 5;
        if (c == 1500) begin
          i_reset = 1'b0;
          idle_n(2);
          i_reset = 1'b1;
        end
        step($urandom_range(0, 99) < pct,
             ($urandom_range(0, 1) != 0) ? {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]}
                                         : 8'($urandom_range(0, 255)),
             $urandom_range(0, 99) < 3);
      end
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
